// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined signed multiply-accumulate over KLEN-pair windows, one scaled pixel out per window.
// Latency: out_valid rises on the 3rd edge counting the edge that accepts the last pair of a window as edge 1.
// Backpressure: a held result (out_valid && !out_ready) freezes the whole pipeline; in_ready mirrors that stall.
//
// Ports:
//   ap_clk, ap_rst_n  clock (rising edge) and asynchronous active-low reset
//   clear             synchronous flush of pipeline, window counter and pending result
//   in_valid/in_ready/a/b          activation/weight pair stream
//   out_valid/out_ready/out_data/out_ovf  window result stream with narrowing-overflow flag
//
// Optional build macro CNN_MAC_SAT_EN: saturate out_data on overflow instead of wrapping.
module cnn_mac_pipe #(
  parameter int A_W   = 10,
  parameter int B_W   = 14,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int KLEN  = 9,
  parameter int SHIFT = 0
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KLEN - 1);

  // Stage registers
  logic signed [A_W-1:0]   a1_q, a1_d;
  logic signed [B_W-1:0]   b1_q, b1_d;
  logic                    v1_q, v1_d;
  logic signed [P_W-1:0]   p_q, p_d;
  logic                    v2_q, v2_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_ovf_q, out_ovf_d;

  // Datapath intermediates
  logic                    ce;
  logic                    new_res;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] s;
  logic [ACC_W-OUT_W:0]    s_hi;
  logic                    ovf;
  logic [OUT_W-1:0]        narrow;

  always_comb begin
    // Only a result that downstream refuses stalls anything.
    ce = !(out_valid_q && !out_ready);

    p_ext = {{(ACC_W-P_W){p_q[P_W-1]}}, p_q};
    // First product of a window ignores whatever acc holds from the previous one.
    sum   = ((cnt_q == '0) ? '0 : acc_q) + p_ext;
    s     = sum >>> SHIFT;

    // s fits in OUT_W signed bits iff its top ACC_W-OUT_W+1 bits are all copies of the sign.
    s_hi  = s[ACC_W-1:OUT_W-1];
    ovf   = !((&s_hi) || !(|s_hi));
`ifdef CNN_MAC_SAT_EN
    if (ovf) begin
      narrow = s[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      narrow = s[OUT_W-1:0];
    end
`else
    narrow = s[OUT_W-1:0];
`endif

    a1_d        = a1_q;
    b1_d        = b1_q;
    v1_d        = v1_q;
    p_d         = p_q;
    v2_d        = v2_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    new_res     = 1'b0;

    if (clear) begin
      v1_d        = 1'b0;
      v2_d        = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (ce) begin
        v1_d = in_valid;
        if (in_valid) begin
          a1_d = $signed(a);
          b1_d = $signed(b);
        end
        p_d  = a1_q * b1_q;
        v2_d = v1_q;
        if (v2_q) begin
          if (cnt_q == CNT_LAST) begin
            new_res    = 1'b1;
            out_data_d = narrow;
            out_ovf_d  = ovf;
            cnt_d      = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // A new result replaces the old one in the same cycle it is consumed.
      out_valid_d = new_res || (out_valid_q && !out_ready);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a1_q        <= '0;
      b1_q        <= '0;
      v1_q        <= 1'b0;
      p_q         <= '0;
      v2_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      v1_q        <= v1_d;
      p_q         <= p_d;
      v2_q        <= v2_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = ce;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// tb_cnn_mac_pipe: directed stimulus with a scoreboard of expected window results for cnn_mac_pipe (KLEN=3).
// Latency: results are compared when they are transferred (out_valid && out_ready sampled before the edge).
// Backpressure: out_ready is driven low in dedicated steps to stall the pipeline.
module tb_cnn_mac_pipe;

  localparam int A_W   = 10;
  localparam int B_W   = 14;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int KLEN  = 3;
  localparam int SHIFT = 0;

  logic             ap_clk;
  logic             ap_rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;

  cnn_mac_pipe #(
    .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .KLEN(KLEN), .SHIFT(SHIFT)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic             o;
  } exp_t;

  exp_t   exp_q[$];
  longint m_sum;
  int     m_cnt;
  logic   last_acc;
  int     n_checks;
  int     n_errors;

  localparam logic [OUT_W-1:0] SAT_EXP =
`ifdef CNN_MAC_SAT_EN
    16'h7fff;
`else
    16'h0000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference narrowing, written from the arithmetic definition in 64-bit.
  function automatic exp_t narrow_model(input longint s_in);
    exp_t        e;
    longint      sh;
    longint      maxv;
    longint      minv;
    logic [63:0] u;
    sh   = s_in >>> SHIFT;
    maxv = (64'sd1 <<< (OUT_W - 1)) - 1;
    minv = -maxv - 1;
    u    = sh;
    e.o  = (sh > maxv) || (sh < minv);
    e.d  = u[OUT_W-1:0];
`ifdef CNN_MAC_SAT_EN
    if (e.o) begin
      u   = (sh < 0) ? minv : maxv;
      e.d = u[OUT_W-1:0];
    end
`endif
    return e;
  endfunction

  task automatic flush_model();
    exp_q.delete();
    m_sum = 0;
    m_cnt = 0;
  endtask

  // Observe the upcoming edge: output transfer, then input accept or flush.
  task automatic sample();
    exp_t e;
    @(negedge ap_clk);
    last_acc = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_out_data", out_data, e.d);
        chk("sb_out_ovf", out_ovf, e.o);
      end
    end
    if (clear) begin
      flush_model();
    end else if (in_valid && in_ready) begin
      last_acc = 1'b1;
      m_sum += longint'($signed(a)) * longint'($signed(b));
      m_cnt++;
      if (m_cnt == KLEN) begin
        exp_q.push_back(narrow_model(m_sum));
        m_sum = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic tick();
    sample();
    @(posedge ap_clk);
    #1;
  endtask

  // Present a pair and wait (bounded) until it is accepted.
  task automatic send(input int av, input int bv);
    logic [31:0] at = av;
    logic [31:0] bt = bv;
    in_valid = 1'b1;
    a        = at[A_W-1:0];
    b        = bt[B_W-1:0];
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("send_accepted", last_acc, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    last_acc  = 1'b0;
    flush_model();
    ap_rst_n  = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    #21 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // Basic window 1*4+2*5+3*6 = 32 and its latency
    send(1, 4);
    send(2, 5);
    send(3, 6);
    tick();
    chk("lat_edge2_valid", out_valid, 0);
    tick();
    chk("lat_edge3_valid", out_valid, 1);
    chk("basic_data", out_data, 32);
    chk("basic_ovf", out_ovf, 0);
    repeat (2) tick();

    // Overflow: 3 * (-512 * -8192) = 12582912
    repeat (3) send(-512, -8192);
    repeat (2) tick();
    chk("ovf_valid", out_valid, 1);
    chk("ovf_data", out_data, {16'h0, SAT_EXP});
    chk("ovf_flag", out_ovf, 1);
    repeat (2) tick();

    // Back-to-back windows: a=1, b=1..6 -> 6 then 15
    for (int i = 1; i <= 6; i++) begin
      send(1, i);
      if (i == 5) begin
        chk("b2b_first_valid", out_valid, 1);
        chk("b2b_first_data", out_data, 6);
      end
    end
    repeat (2) tick();
    chk("b2b_second_valid", out_valid, 1);
    chk("b2b_second_data", out_data, 15);
    repeat (2) tick();

    // Backpressure: result 9 held, stalled pair then accepted after release
    out_ready = 1'b0;
    send(2, 1);
    send(3, 1);
    send(4, 1);
    repeat (2) tick();
    chk("bp_valid", out_valid, 1);
    in_valid = 1'b1;
    a        = 10'd5;
    b        = 14'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_data_stable", out_data, 9);
      chk("bp_valid_held", out_valid, 1);
    end
    out_ready = 1'b1;
    repeat (3) send(5, 2);
    repeat (4) tick();

    // Mid-window asynchronous reset, then a fresh window 1*2 x3 = 6
    send(7, 7);
    send(7, 7);
    repeat (2) tick();
    #2 ap_rst_n = 1'b0;
    #1;
    flush_model();
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_ovf", out_ovf, 0);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    repeat (3) send(1, 2);
    repeat (2) tick();
    chk("post_rst_data", out_data, 6);
    repeat (2) tick();

    // clear with a pending result and one pair in S2, then 2*3 x3 = 18
    out_ready = 1'b0;
    repeat (3) send(1, 1);
    send(9, 9);
    tick();
    chk("pre_clear_valid", out_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) send(2, 3);
    repeat (2) tick();
    chk("post_clear_valid", out_valid, 1);
    chk("post_clear_data", out_data, 18);
    repeat (3) tick();

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cnn_mac_pipe.md
Name: cnn_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate for convolution windows; successor to the fixed 10s x 14s combinational DSP48 multiplier.
- Accepts one (activation, weight) pair per cycle and accumulates KLEN products (one kernel window, e.g. 3x3 = 9).
- Emits one scaled output pixel per window through a valid/ready stream.
- Sits between the line-buffer/weight-ROM feeders and the pooling/activation stage.

Parameters:
A_W, 10, signed activation width
B_W, 14, signed weight width
ACC_W, 32, accumulator width; must be >= A_W+B_W+ceil(log2(KLEN))
OUT_W, 16, output width
KLEN, 9, products per window (>= 1)
SHIFT, 0, arithmetic right shift applied to the final sum before narrowing

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush: empties the pipeline and zeroes the window counter; out_valid drops
in_valid  in  1  a/b valid
in_ready  out  1  pair accepted when in_valid && in_ready
a  in  A_W  signed activation
b  in  B_W  signed weight
out_valid  out  1  result valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  OUT_W  signed window result
out_ovf  out  1  narrowing overflowed for the current out_data

Behaviour:
- Reset (ap_rst_n low, asynchronous) forces the following to 0: all pipeline registers, valid bits, accumulator, window counter, out_valid, out_data and out_ovf. in_ready is 1 while in reset-released idle.
- Global stall: ce = !(out_valid && !out_ready). in_ready = ce. Every pipeline register updates only when ce = 1.
- S1: on accept, register a, b and v1 = 1. When in_valid = 0 under ce, v1 = 0.
- S2: p = $signed(a1) * $signed(b1), full width A_W+B_W; register p and v2 = v1.
- S3 (accumulate): when v2 = 1:
  - sum = (cnt == 0 ? 0 : acc) + sext(p) at ACC_W.
  - If cnt == KLEN-1: load the output register from sum, set out_valid = 1, set cnt = 0.
  - Otherwise: acc = sum, cnt = cnt + 1.
- Output register:
  - When out_valid && out_ready and no new result in the same cycle, out_valid goes to 0.
  - A new result may load in the same cycle the old one is consumed, so back-to-back output is allowed.
- Latency: out_valid is high 3 ap_clk edges after the edge that accepts the KLEN-th pair. The accepting edge counts as edge 1.
- Throughput: 1 pair per cycle. Input bubbles (in_valid = 0) are allowed anywhere inside a window and do not reset cnt.
- Narrowing:
  - s = sum >>> SHIFT (arithmetic, floors toward -inf).
  - Default: out_data = s[OUT_W-1:0].
  - out_ovf = 1 when s is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- clear: takes priority over all else except reset.
  - Zeroes v1, v2, cnt, acc and out_valid at the next edge, regardless of ce.
  - The pair presented in the same cycle is discarded.
- KLEN = 1: every product is emitted directly; cnt stays 0.
- Reset mid-window: the partial sum is lost and the next accepted pair starts a fresh window.

Optional Feature:
- Macro: CNN_MAC_SAT_EN.
- Defined: on overflow, out_data saturates to 2^(OUT_W-1)-1 (positive) or -2^(OUT_W-1) (negative). out_ovf behaves as in Behaviour.
- Undefined: out_data wraps (truncation). out_ovf is still reported.

Test Plan:
- KLEN=3: a = 1,2,3 and b = 4,5,6 on consecutive cycles, out_ready = 1 -> out_data = 32, out_ovf = 0, out_valid high exactly 3 edges after the 3rd accept.
- KLEN=3, OUT_W=16: a = -512 (x3), b = -8192 (x3), sum 12582912 -> with CNN_MAC_SAT_EN out_data = 32767; without it out_data = 0. out_ovf = 1 in both builds.
- KLEN=3, continuous 6 pairs (all a = 1, b = 1..6), out_ready = 1 -> results 6 then 15 with no bubble cycle between windows.
- Backpressure: hold out_ready = 0 while a result is valid -> in_ready = 0, out_data stable, no pair lost. Release out_ready -> the next window completes with the correct sum.
- Mid-window: after 2 of 3 pairs (a = 7, b = 7), pulse ap_rst_n low (asynchronously) -> all outputs 0 immediately. Then a = 1,1,1 and b = 2,2,2 -> out_data = 6.
- clear asserted with 1 pair in S2 and a result pending -> out_valid = 0 the next cycle. The following window of a = 2,2,2 and b = 3,3,3 -> out_data = 18.
